pcm_mem_engine: RTL and testbench

Parametrised PCM memory fill-and-verify engine between the NIOS control PIOs and the PCM on-chip memory's Avalon-MM slave port. On command from NIOS, it fills the memory with one of two data patterns, or reads it back and checks it against the same pattern. It reports busy, done and error status, plus the first failing address and a mismatch count. Successor to the fixed 11-bit/16-bit single-pattern fill controller, with width, depth, pattern and read-latency parameters, a verify mode and an abort path.

---
 rtl/pcm_mem_engine.sv | 152 +++++++++++++++
 tb/tb_pcm_mem_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_mem_engine.sv
// pcm_mem_engine: fills the PCM on-chip memory with a data pattern or reads it back and
// checks it, reporting busy/done/error status and the first failing address to NIOS.
module pcm_mem_engine #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter logic [DATA_W-1:0] PAT_A = DATA_W'(16'h0705),
    parameter logic [DATA_W-1:0] PAT_B = DATA_W'(16'h0806),
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            pccm_ctl_con_export,
    output logic [3:0]            pccm_rsp_con_export,
    output logic [ADDR_W-1:0]     err_addr_export,
    output logic [ADDR_W:0]       err_cnt_export,
    output logic [ADDR_W-1:0]     pcm_mem_mm_address,
    output logic                  pcm_mem_mm_chipselect,
    output logic                  pcm_mem_mm_clken,
    output logic                  pcm_mem_mm_write,
    input  logic [DATA_W-1:0]     pcm_mem_mm_readdata,
    output logic [DATA_W-1:0]     pcm_mem_mm_writedata,
    output logic [DATA_W/8-1:0]   pcm_mem_mm_byteenable
);
    localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, FILL, VERIFY, DRAIN, DONE} state_t;

    state_t              state_q;
    logic                inc_q;
    logic [CW-1:0]       dcnt_q;
    logic [3:0]          rsp_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ADDR_W-1:0]   err_addr_q;
    logic [ADDR_W:0]     err_cnt_q;
    logic                pv_q [RD_LAT];
    logic [ADDR_W-1:0]   pa_q [RD_LAT];
    logic [DATA_W-1:0]   pe_q [RD_LAT];

    logic [3:0]          ctl;
    logic                abort, mism, last, start, fill_cmd, inc_cmd;
    logic [ADDR_W-1:0]   addr_nx;
    logic [ADDR_W-1:0]   err_addr_d;
    logic [ADDR_W:0]     err_cnt_d;

    function automatic logic [DATA_W-1:0] pat(input logic inc, input logic [ADDR_W-1:0] a);
        return inc ? DATA_W'(a) : (a[0] ? PAT_B : PAT_A);
    endfunction

    assign ctl = pccm_ctl_con_export;

    always_comb begin
        abort      = (state_q == FILL || state_q == VERIFY || state_q == DRAIN) && ctl == 4'h8;
        start      = ctl == 4'h2 || ctl == 4'h3 || ctl == 4'h5 || ctl == 4'h6;
        fill_cmd   = ctl == 4'h2 || ctl == 4'h3;
        inc_cmd    = ctl == 4'h3 || ctl == 4'h6;
        last       = &addr_q;
        addr_nx    = addr_q + ADDR_W'(1);
        mism       = pv_q[RD_LAT-1] && pcm_mem_mm_readdata != pe_q[RD_LAT-1] && !abort;
        // DEPTH is exactly the count MSB, so saturation only needs that bit
        err_cnt_d  = mism && !err_cnt_q[ADDR_W] ? err_cnt_q + (ADDR_W+1)'(1) : err_cnt_q;
        err_addr_d = mism && err_cnt_q == '0 ? pa_q[RD_LAT-1] : err_addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            inc_q      <= 1'b0;
            dcnt_q     <= '0;
            rsp_q      <= 4'h0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pa_q[i] <= '0;
                pe_q[i] <= '0;
            end
        end else begin
            // Expected data and address travel alongside each read until its data returns
            pv_q[0] <= state_q == VERIFY && !abort;
            pa_q[0] <= addr_q;
            pe_q[0] <= pat(inc_q, addr_q);
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1] && !abort;
                pa_q[i] <= pa_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            if (abort) begin
                state_q <= IDLE;
                rsp_q   <= 4'h0;
                write_q <= 1'b0;
                addr_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        state_q    <= fill_cmd ? FILL : VERIFY;
                        inc_q      <= inc_cmd;
                        addr_q     <= '0;
                        write_q    <= fill_cmd;
                        wdata_q    <= pat(inc_cmd, '0);
                        rsp_q      <= 4'h2;
                        err_cnt_q  <= '0;
                        err_addr_q <= '0;
                    end
                    FILL: if (last) begin
                        state_q <= DONE;
                        write_q <= 1'b0;
                        addr_q  <= '0;
                        rsp_q   <= 4'h4;
                    end else begin
                        addr_q  <= addr_nx;
                        wdata_q <= pat(inc_q, addr_nx);
                    end
                    VERIFY: if (last) begin
                        state_q <= DRAIN;
                        addr_q  <= '0;
                        dcnt_q  <= '0;
                    end else begin
                        addr_q <= addr_nx;
                    end
                    DRAIN: if (dcnt_q == CW'(RD_LAT - 1)) begin
                        state_q <= DONE;
                        rsp_q   <= err_cnt_d != '0 ? 4'h8 : 4'h4;
                    end else begin
                        dcnt_q <= dcnt_q + CW'(1);
                    end
                    DONE: if (ctl == 4'h4) begin
                        state_q <= IDLE;
                        rsp_q   <= 4'h0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pccm_rsp_con_export   = rsp_q;
    assign err_addr_export       = err_addr_q;
    assign err_cnt_export        = err_cnt_q;
    assign pcm_mem_mm_address    = addr_q;
    assign pcm_mem_mm_chipselect = 1'b1;
    assign pcm_mem_mm_clken      = 1'b1;
    assign pcm_mem_mm_write      = write_q;
    assign pcm_mem_mm_writedata  = wdata_q;
    assign pcm_mem_mm_byteenable = '1;
endmodule

// File: tb/tb_pcm_mem_engine.sv
// tb_pcm_mem_engine: scoreboarded bench for the default engine and a small
// ADDR_W=4 / DATA_W=32 / RD_LAT=3 instance, each with its own memory model.
module tb_pcm_mem_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    logic [3:0]  ctl0 = 4'h0, rsp0;
    logic [10:0] ea0, addr0;
    logic [11:0] ec0;
    logic        cs0, ck0, wr0;
    logic [15:0] rd0, wd0;
    logic [1:0]  be0;

    logic [3:0]  ctl1 = 4'h0, rsp1, ea1, addr1, be1;
    logic [4:0]  ec1;
    logic        cs1, ck1, wr1;
    logic [31:0] rd1, wd1;

    pcm_mem_engine u0 (
        .clk(clk), .reset(reset), .pccm_ctl_con_export(ctl0), .pccm_rsp_con_export(rsp0),
        .err_addr_export(ea0), .err_cnt_export(ec0), .pcm_mem_mm_address(addr0),
        .pcm_mem_mm_chipselect(cs0), .pcm_mem_mm_clken(ck0), .pcm_mem_mm_write(wr0),
        .pcm_mem_mm_readdata(rd0), .pcm_mem_mm_writedata(wd0), .pcm_mem_mm_byteenable(be0));

    pcm_mem_engine #(.ADDR_W(4), .DATA_W(32), .RD_LAT(3)) u1 (
        .clk(clk), .reset(reset), .pccm_ctl_con_export(ctl1), .pccm_rsp_con_export(rsp1),
        .err_addr_export(ea1), .err_cnt_export(ec1), .pcm_mem_mm_address(addr1),
        .pcm_mem_mm_chipselect(cs1), .pcm_mem_mm_clken(ck1), .pcm_mem_mm_write(wr1),
        .pcm_mem_mm_readdata(rd1), .pcm_mem_mm_writedata(wd1), .pcm_mem_mm_byteenable(be1));

    // Memory models; cor* marks words whose read data comes back inverted
    logic [15:0] mem0 [2048];
    logic        cor0 [2048];
    logic [31:0] mem1 [16];
    logic        cor1 [16];
    logic [31:0] rp1  [3];

    always_ff @(posedge clk) begin
        if (wr0) mem0[addr0] <= wd0;
        rd0 <= cor0[addr0] ? ~mem0[addr0] : mem0[addr0];
        if (wr1) mem1[addr1] <= wd1;
        rp1[0] <= cor1[addr1] ? ~mem1[addr1] : mem1[addr1];
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end
    assign rd1 = rp1[2];

    typedef struct {int a; logic [31:0] d;} exp_t;
    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    // Starts an operation, then pops one expected address/data per busy cycle
    task automatic run(input bit d1, input logic [3:0] code, output int total, output int busy);
        exp_t e;
        int n, ca;
        bit fill, inc, cw;
        logic [31:0] cd;
        logic [3:0] cr;
        n = d1 ? 16 : 2048;
        fill = code inside {4'h2, 4'h3};
        inc = code inside {4'h3, 4'h6};
        for (int a = 0; a < n; a++) begin
            e.a = a;
            e.d = inc ? 32'(a) : (a % 2 == 1 ? 32'h0806 : 32'h0705);
            sbq.push_back(e);
        end
        @(negedge clk);
        if (d1) ctl1 = code; else ctl0 = code;
        total = 0;
        busy = 0;
        while (total < 5000) begin
            @(negedge clk);
            ctl0 = 4'h0;
            ctl1 = 4'h0;
            total++;
            ca = d1 ? int'(addr1) : int'(addr0);
            cw = d1 ? wr1 : wr0;
            cd = d1 ? wd1 : 32'(wd0);
            cr = d1 ? rsp1 : rsp0;
            if (cr == 4'h2) begin
                busy++;
                checks++;
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    if (ca != e.a || cw != fill || (fill && cd !== e.d)) begin
                        errors++;
                        $display("FAIL busy_cycle op=%h: addr=%0h wr=%0b wd=%0h, expected addr=%0h wr=%0b wd=%0h", code, ca, cw, cd, e.a, fill, e.d);
                    end
                end else if (cw) begin
                    errors++;
                    $display("FAIL drain_write op=%h: write=1, expected 0", code);
                end
            end else if (cr == 4'h4 || cr == 4'h8) begin
                break;
            end
        end
        checks++;
        if (sbq.size() != 0 || total >= 5000) begin
            errors++;
            $display("FAIL op_complete op=%h: %0d accesses missing, %0d cycles, expected 0 missing within budget", code, sbq.size(), total);
        end
        sbq.delete();
    endtask

    task automatic ack(input bit d1);
        @(negedge clk);
        if (d1) ctl1 = 4'h4; else ctl0 = 4'h4;
        @(negedge clk);
        ctl0 = 4'h0;
        ctl1 = 4'h0;
        checks++;
        if ((d1 ? rsp1 : rsp0) !== 4'h0) begin
            errors++;
            $display("FAIL ack_rsp: rsp=%h, expected 0", d1 ? rsp1 : rsp0);
        end
    endtask

    task automatic test_reset();
        logic [31:0] got [12];
        logic [31:0] want [12];
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        got  = '{32'(rsp0), 32'(wr0), 32'(addr0), 32'(wd0), 32'(ea0), 32'(ec0), 32'(be0), 32'(cs0 & ck0),
                 32'(rsp1), 32'(wd1), 32'(ec1), 32'(be1)};
        want = '{0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 15};
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL reset_value[%0d]: got %0h, expected %0h", i, got[i], want[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_fill_alt();
        int total, busy;
        run(0, 4'h2, total, busy);
        checks++; if (total != 2049 || busy != 2048) begin errors++; $display("FAIL fill_alt_timing: total=%0d busy=%0d, expected 2049/2048", total, busy); end
        checks++; if (rsp0 !== 4'h4 || ec0 !== 12'd0) begin errors++; $display("FAIL fill_alt_status: rsp=%h cnt=%0d, expected 4/0", rsp0, ec0); end
        checks++; if (mem0[0] !== 16'h0705 || mem0[1] !== 16'h0806 || mem0[2047] !== 16'h0806) begin errors++; $display("FAIL fill_alt_mem: %h %h %h, expected 0705 0806 0806", mem0[0], mem0[1], mem0[2047]); end
        ack(0);
    endtask

    task automatic test_verify_alt();
        int total, busy;
        run(0, 4'h5, total, busy);
        checks++; if (total != 2050 || busy != 2049) begin errors++; $display("FAIL verify_alt_timing: total=%0d busy=%0d, expected 2050/2049", total, busy); end
        checks++; if (rsp0 !== 4'h4 || ec0 !== 12'd0 || ea0 !== 11'd0) begin errors++; $display("FAIL verify_alt_status: rsp=%h cnt=%0d addr=%h, expected 4/0/0", rsp0, ec0, ea0); end
        ack(0);
    endtask

    task automatic test_mismatch();
        int total, busy;
        run(0, 4'h3, total, busy);
        checks++; if (rsp0 !== 4'h4 || mem0[11'h123] !== 16'h0123) begin errors++; $display("FAIL fill_inc: rsp=%h mem[123]=%h, expected 4/0123", rsp0, mem0[11'h123]); end
        ack(0);
        cor0[11'h123] = 1'b1;
        cor0[11'h7FF] = 1'b1;
        run(0, 4'h6, total, busy);
        checks++; if (rsp0 !== 4'h8 || ea0 !== 11'h123 || ec0 !== 12'd2) begin errors++; $display("FAIL mismatch_status: rsp=%h addr=%h cnt=%0d, expected 8/123/2", rsp0, ea0, ec0); end
        checks++; if (total != 2050) begin errors++; $display("FAIL mismatch_timing: total=%0d, expected 2050", total); end
        ack(0);
        cor0[11'h123] = 1'b0;
        cor0[11'h7FF] = 1'b0;
    endtask

    task automatic test_abort_fill();
        bit hit = 1'b0, late_wr = 1'b0;
        @(negedge clk);
        ctl0 = 4'h2;
        @(negedge clk);
        ctl0 = 4'h0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            if (wr0 && addr0 == 11'h400) begin ctl0 = 4'h8; hit = 1'b1; end
            else @(negedge clk);
        end
        @(negedge clk);
        ctl0 = 4'h0;
        checks++; if (!hit || rsp0 !== 4'h0 || wr0 !== 1'b0 || addr0 !== 11'd0) begin errors++; $display("FAIL abort_fill: reached=%0b rsp=%h wr=%b addr=%h, expected 1/0/0/0", hit, rsp0, wr0, addr0); end
        repeat (10) begin @(negedge clk); if (wr0) late_wr = 1'b1; end
        checks++; if (late_wr) begin errors++; $display("FAIL abort_quiet: write seen after abort, expected none"); end
        checks++; if (mem0[11'h400] !== 16'h0705 || mem0[11'h401] !== 16'h0401) begin errors++; $display("FAIL abort_mem: mem[400]=%h mem[401]=%h, expected 0705/0401", mem0[11'h400], mem0[11'h401]); end
    endtask

    task automatic test_abort_verify();
        bit hit = 1'b0;
        cor0[5] = 1'b1;
        @(negedge clk);
        ctl0 = 4'h5;
        @(negedge clk);
        ctl0 = 4'h0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            if (addr0 == 11'h100) begin ctl0 = 4'h8; hit = 1'b1; end
            else @(negedge clk);
        end
        @(negedge clk);
        ctl0 = 4'h0;
        checks++; if (!hit || rsp0 !== 4'h0 || ec0 !== 12'd1 || ea0 !== 11'd5) begin errors++; $display("FAIL abort_verify: reached=%0b rsp=%h cnt=%0d addr=%h, expected 1/0/1/5", hit, rsp0, ec0, ea0); end
        repeat (5) @(negedge clk);
        checks++; if (ec0 !== 12'd1 || ea0 !== 11'd5) begin errors++; $display("FAIL abort_hold: cnt=%0d addr=%h, expected 1/5", ec0, ea0); end
    endtask

    task automatic test_reset_mid();
        int total, busy;
        @(negedge clk);
        ctl0 = 4'h5;
        @(negedge clk);
        ctl0 = 4'h0;
        repeat (100) @(negedge clk);
        checks++; if (rsp0 !== 4'h2 || ec0 !== 12'd1) begin errors++; $display("FAIL pre_reset: rsp=%h cnt=%0d, expected 2/1", rsp0, ec0); end
        test_reset();
        cor0[5] = 1'b0;
        run(0, 4'h2, total, busy);
        ack(0);
        run(0, 4'h5, total, busy);
        checks++; if (busy != 2049 || rsp0 !== 4'h4 || ec0 !== 12'd0) begin errors++; $display("FAIL post_reset_verify: busy=%0d rsp=%h cnt=%0d, expected 2049/4/0", busy, rsp0, ec0); end
        ack(0);
    endtask

    task automatic test_sweep();
        int total, busy;
        run(1, 4'h2, total, busy);
        checks++; if (total != 17 || busy != 16 || rsp1 !== 4'h4) begin errors++; $display("FAIL sweep_fill: total=%0d busy=%0d rsp=%h, expected 17/16/4", total, busy, rsp1); end
        checks++; if (mem1[14] !== 32'h0705 || mem1[15] !== 32'h0806) begin errors++; $display("FAIL sweep_mem: %h %h, expected 00000705 00000806", mem1[14], mem1[15]); end
        @(negedge clk);
        ctl1 = 4'h8;
        @(negedge clk);
        checks++; if (rsp1 !== 4'h4) begin errors++; $display("FAIL abort_in_done: rsp=%h, expected 4", rsp1); end
        ack(1);
        run(1, 4'h5, total, busy);
        checks++; if (total != 20 || busy != 19 || rsp1 !== 4'h4 || ec1 !== 5'd0) begin errors++; $display("FAIL sweep_verify: total=%0d busy=%0d rsp=%h cnt=%0d, expected 20/19/4/0", total, busy, rsp1, ec1); end
        ack(1);
        cor1[15] = 1'b1;
        run(1, 4'h5, total, busy);
        checks++; if (rsp1 !== 4'h8 || ea1 !== 4'd15 || ec1 !== 5'd1) begin errors++; $display("FAIL sweep_err15: rsp=%h addr=%0d cnt=%0d, expected 8/15/1", rsp1, ea1, ec1); end
        ack(1);
        for (int i = 0; i < 16; i++) cor1[i] = 1'b1;
        run(1, 4'h5, total, busy);
        checks++; if (rsp1 !== 4'h8 || ea1 !== 4'd0 || ec1 !== 5'd16) begin errors++; $display("FAIL sweep_all_err: rsp=%h addr=%0d cnt=%0d, expected 8/0/16", rsp1, ea1, ec1); end
        ack(1);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) cor0[i] = 1'b0;
        for (int i = 0; i < 16; i++) cor1[i] = 1'b0;
        test_reset();
        test_fill_alt();
        test_verify_alt();
        test_mismatch();
        test_abort_fill();
        test_abort_verify();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
